riscv_ctrl_im: RTL
==================

// Module: riscv_ctrl_im
// PURPOSE
//  Decode-stage control unit for the pipelined core, RV32I plus optional RV32M.
//  Base-ISA controls are combinational, with the same encodings as the existing decoder.
//  A multi-cycle sequencer issues MUL/DIV operations to the M-unit and stalls decode
//  until the result is ready. Sits in ID and drives the ID/EX control bundle plus the hazard unit.
// PARAMETERS
//  EN_M        1   1: decode RV32M; 0: M encodings flagged illegal, sequencer never leaves IDLE
//  MUL_CYCLES  2   M-unit latency for funct3[2]=0 (MUL*), >=1
//  DIV_CYCLES  33  M-unit latency for funct3[2]=1 (DIV*/REM*), >=1
//  (local) CNT_W = $clog2(max(MUL_CYCLES,DIV_CYCLES)+1)
// PORTS
//  i_clk               in   1  clock, rising edge
//  i_rst               in   1  reset, asynchronous, active-high
//  i_ctrl_valid        in   1  ID holds a valid instruction
//  i_ctrl_flush        in   1  ID instruction is being squashed this cycle
//  i_ctrl_opcode       in   7  instr[6:0]
//  i_ctrl_funct3       in   3  instr[14:12]
//  i_ctrl_funct7_5b    in   1  instr[30]
//  i_ctrl_funct7_0b    in   1  instr[25]; M-extension select
//  o_ctrl_src_imm      out  3  `SRC_IMM_* select
//  o_ctrl_src_rd       out  2  `SRC_RD_* select
//  o_ctrl_src_alu_a/b  out  1  `SRC_ALU_A_* / `SRC_ALU_B_* select
//  o_ctrl_reg_wr_en    out  1  register-file write enable
//  o_ctrl_mem_wr_en    out  1  data-memory write enable
//  o_ctrl_mem_byte_sel out  4  byte lanes: 0001 B/BU, 0011 H/HU, 1111 otherwise
//  o_ctrl_alu_ctrl     out  4  `ALU_CTRL_* operation
//  o_ctrl_md_sel       out  1  writeback takes the M-unit result
//  o_ctrl_illegal      out  1  unknown opcode, or M encoding with EN_M=0
//  o_jalr_d/o_jump_d/o_branch_d/o_zero_condition  out 1 each  branch/jump controls
//  o_md_start          out  1  one-cycle pulse: M-unit starts o_md_op
//  o_md_op             out  3  latched funct3 of the in-flight M op
//  o_md_done           out  1  one-cycle pulse: M-unit result valid
//  o_md_stall          out  1  hold PC/IF/ID; bubble into EX
// BEHAVIOUR
//  Decode (combinational)
//  - RV32I decode: every output is fully defined for all inputs; no latches.
//  - R/I ALU, funct3=000: SUB only for R-type with instr[30]=1; ADD otherwise.
//  - R/I ALU, funct3=101: SRA if instr[30]=1, SRL otherwise.
//  - Branch ops map to ALU SUB/SLT/SLTU.
//  - o_zero_condition = 1 for BNE/BLT/BLTU; 0 otherwise.
//  - md_req = EN_M & opcode==`OPCODE_R_OP & funct7_0b & ~funct7_5b.
//  - On md_req: reg_wr_en=1, md_sel=1, alu_ctrl=`ALU_CTRL_NOP, src_alu_b=RS2.
//  - If ~i_ctrl_valid, i_ctrl_flush or o_ctrl_illegal: reg_wr_en, mem_wr_en, jump,
//    jalr and branch are forced to 0.
//  Sequencer FSM (states IDLE, BUSY, DONE)
//  - Reset (async): state=IDLE, cnt=0, o_md_op=0, o_md_start=0, o_md_done=0.
//  - IDLE: on i_ctrl_valid & md_req & ~flush, latch o_md_op=funct3,
//    cnt=LAT-1 (LAT=funct3[2]?DIV_CYCLES:MUL_CYCLES), and go to BUSY.
//  - BUSY: o_md_start=1 in the first BUSY cycle only (registered); cnt decrements each cycle.
//    When cnt==0 go to DONE. On flush go to IDLE; no done pulse is issued.
//  - DONE: o_md_done=1; always go to IDLE. The held instruction retires this cycle.
//    A back-to-back M op is accepted in the following IDLE cycle.
//  - o_md_stall = ((IDLE & valid & md_req) | BUSY) & ~flush; combinational, low in DONE.
//  - Stall length is LAT+1 cycles; done is asserted LAT+1 cycles after the request cycle.
//  - Async reset mid-operation drops stall in the same cycle; no start or done pulse follows.
// TESTING
//  1. addi x1,x0,5 (valid) -> src_imm=I, src_alu_b=IMM, alu=ADD, reg_wr_en=1, stall=0.
//  2. mul, MUL_CYCLES=2, request at cycle 0 -> stall in cycles 0-2, start@1, done@3, md_op=000.
//  3. divu, DIV_CYCLES=33 -> stall for 34 cycles, done@34, md_op=101, md_sel=1.
//  4. div with flush at BUSY cycle 5 -> stall=0 in that cycle, IDLE next cycle, no done pulse.
//  5. mul then rem back-to-back -> second start exactly 2 cycles after the first done, md_op=110.
//  6. EN_M=0 with a mul encoding -> illegal=1, reg_wr_en=0, stall never asserted.
//     Plus: i_rst asserted mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_ctrl_im.sv
// Decode-stage control for RV32I with optional RV32M: combinational base decode plus
// a small sequencer that issues MUL/DIV to the M-unit and stalls decode until done.
module riscv_ctrl_im #(
    parameter int EN_M       = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ctrl_valid,
    input  logic       i_ctrl_flush,
    input  logic [6:0] i_ctrl_opcode,
    input  logic [2:0] i_ctrl_funct3,
    input  logic       i_ctrl_funct7_5b,
    input  logic       i_ctrl_funct7_0b,
    output logic [2:0] o_ctrl_src_imm,
    output logic [1:0] o_ctrl_src_rd,
    output logic       o_ctrl_src_alu_a,
    output logic       o_ctrl_src_alu_b,
    output logic       o_ctrl_reg_wr_en,
    output logic       o_ctrl_mem_wr_en,
    output logic [3:0] o_ctrl_mem_byte_sel,
    output logic [3:0] o_ctrl_alu_ctrl,
    output logic       o_ctrl_md_sel,
    output logic       o_ctrl_illegal,
    output logic       o_jalr_d,
    output logic       o_jump_d,
    output logic       o_branch_d,
    output logic       o_zero_condition,
    output logic       o_md_start,
    output logic [2:0] o_md_op,
    output logic       o_md_done,
    output logic       o_md_stall
);

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_I_OP   = 7'b0010011;
    localparam logic [6:0] OPCODE_R_OP   = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] SRC_IMM_I = 3'd0;
    localparam logic [2:0] SRC_IMM_S = 3'd1;
    localparam logic [2:0] SRC_IMM_B = 3'd2;
    localparam logic [2:0] SRC_IMM_U = 3'd3;
    localparam logic [2:0] SRC_IMM_J = 3'd4;

    localparam logic [1:0] SRC_RD_ALU = 2'd0;
    localparam logic [1:0] SRC_RD_MEM = 2'd1;
    localparam logic [1:0] SRC_RD_PC4 = 2'd2;
    localparam logic [1:0] SRC_RD_IMM = 2'd3;

    localparam logic SRC_ALU_A_RS1 = 1'b0;
    localparam logic SRC_ALU_A_PC  = 1'b1;
    localparam logic SRC_ALU_B_RS2 = 1'b0;
    localparam logic SRC_ALU_B_IMM = 1'b1;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd9;
    localparam logic [3:0] ALU_CTRL_NOP  = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);

    logic             m_encoding;
    logic             md_req;
    logic             md_accept;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       alu_by_funct3;
    logic [3:0]       lsu_byte_sel;

    assign m_encoding = (i_ctrl_opcode == OPCODE_R_OP) & i_ctrl_funct7_0b & ~i_ctrl_funct7_5b;
    assign md_req     = (EN_M != 0) & m_encoding;
    assign md_accept  = (state == ST_IDLE) & i_ctrl_valid & md_req & ~i_ctrl_flush;

    // Shared R/I ALU op; SUB is only meaningful for R-type, so the caller masks it.
    always_comb begin
        alu_by_funct3 = ALU_CTRL_ADD;
        case (i_ctrl_funct3)
            3'b000:  alu_by_funct3 = ALU_CTRL_ADD;
            3'b001:  alu_by_funct3 = ALU_CTRL_SLL;
            3'b010:  alu_by_funct3 = ALU_CTRL_SLT;
            3'b011:  alu_by_funct3 = ALU_CTRL_SLTU;
            3'b100:  alu_by_funct3 = ALU_CTRL_XOR;
            3'b101:  alu_by_funct3 = i_ctrl_funct7_5b ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            3'b110:  alu_by_funct3 = ALU_CTRL_OR;
            default: alu_by_funct3 = ALU_CTRL_AND;
        endcase
    end

    always_comb begin
        case (i_ctrl_funct3[1:0])
            2'b00:   lsu_byte_sel = 4'b0001;
            2'b01:   lsu_byte_sel = 4'b0011;
            default: lsu_byte_sel = 4'b1111;
        endcase
    end

    always_comb begin
        o_ctrl_src_imm      = SRC_IMM_I;
        o_ctrl_src_rd       = SRC_RD_ALU;
        o_ctrl_src_alu_a    = SRC_ALU_A_RS1;
        o_ctrl_src_alu_b    = SRC_ALU_B_RS2;
        o_ctrl_reg_wr_en    = 1'b0;
        o_ctrl_mem_wr_en    = 1'b0;
        o_ctrl_mem_byte_sel = 4'b1111;
        o_ctrl_alu_ctrl     = ALU_CTRL_ADD;
        o_ctrl_md_sel       = 1'b0;
        o_ctrl_illegal      = 1'b0;
        o_jalr_d            = 1'b0;
        o_jump_d            = 1'b0;
        o_branch_d          = 1'b0;
        o_zero_condition    = 1'b0;
        case (i_ctrl_opcode)
            OPCODE_LUI: begin
                o_ctrl_src_imm   = SRC_IMM_U;
                o_ctrl_src_rd    = SRC_RD_IMM;
                o_ctrl_reg_wr_en = 1'b1;
            end
            OPCODE_AUIPC: begin
                o_ctrl_src_imm   = SRC_IMM_U;
                o_ctrl_src_alu_a = SRC_ALU_A_PC;
                o_ctrl_src_alu_b = SRC_ALU_B_IMM;
                o_ctrl_reg_wr_en = 1'b1;
            end
            OPCODE_JAL: begin
                o_ctrl_src_imm   = SRC_IMM_J;
                o_ctrl_src_rd    = SRC_RD_PC4;
                o_ctrl_reg_wr_en = 1'b1;
                o_jump_d         = 1'b1;
            end
            OPCODE_JALR: begin
                o_ctrl_src_rd    = SRC_RD_PC4;
                o_ctrl_src_alu_b = SRC_ALU_B_IMM;
                o_ctrl_reg_wr_en = 1'b1;
                o_jump_d         = 1'b1;
                o_jalr_d         = 1'b1;
            end
            OPCODE_BRANCH: begin
                o_ctrl_src_imm = SRC_IMM_B;
                o_branch_d     = 1'b1;
                case (i_ctrl_funct3)
                    3'b001: begin o_ctrl_alu_ctrl = ALU_CTRL_SUB;  o_zero_condition = 1'b1; end
                    3'b100: begin o_ctrl_alu_ctrl = ALU_CTRL_SLT;  o_zero_condition = 1'b1; end
                    3'b101: o_ctrl_alu_ctrl = ALU_CTRL_SLT;
                    3'b110: begin o_ctrl_alu_ctrl = ALU_CTRL_SLTU; o_zero_condition = 1'b1; end
                    3'b111: o_ctrl_alu_ctrl = ALU_CTRL_SLTU;
                    default: o_ctrl_alu_ctrl = ALU_CTRL_SUB;
                endcase
            end
            OPCODE_LOAD: begin
                o_ctrl_src_rd       = SRC_RD_MEM;
                o_ctrl_src_alu_b    = SRC_ALU_B_IMM;
                o_ctrl_reg_wr_en    = 1'b1;
                o_ctrl_mem_byte_sel = lsu_byte_sel;
            end
            OPCODE_STORE: begin
                o_ctrl_src_imm      = SRC_IMM_S;
                o_ctrl_src_alu_b    = SRC_ALU_B_IMM;
                o_ctrl_mem_wr_en    = 1'b1;
                o_ctrl_mem_byte_sel = lsu_byte_sel;
            end
            OPCODE_I_OP: begin
                o_ctrl_src_alu_b = SRC_ALU_B_IMM;
                o_ctrl_reg_wr_en = 1'b1;
                o_ctrl_alu_ctrl  = alu_by_funct3;
            end
            OPCODE_R_OP: begin
                o_ctrl_reg_wr_en = 1'b1;
                if (i_ctrl_funct3 == 3'b000 && i_ctrl_funct7_5b)
                    o_ctrl_alu_ctrl = ALU_CTRL_SUB;
                else
                    o_ctrl_alu_ctrl = alu_by_funct3;
            end
            OPCODE_FENCE, OPCODE_SYSTEM: begin
            end
            default: o_ctrl_illegal = 1'b1;
        endcase

        if (md_req) begin
            o_ctrl_reg_wr_en = 1'b1;
            o_ctrl_md_sel    = 1'b1;
            o_ctrl_alu_ctrl  = ALU_CTRL_NOP;
            o_ctrl_src_alu_b = SRC_ALU_B_RS2;
        end
        if (m_encoding && EN_M == 0)
            o_ctrl_illegal = 1'b1;

        // Squashed, empty or illegal slots must never change architectural state.
        if (!i_ctrl_valid || i_ctrl_flush || o_ctrl_illegal) begin
            o_ctrl_reg_wr_en = 1'b0;
            o_ctrl_mem_wr_en = 1'b0;
            o_jump_d         = 1'b0;
            o_jalr_d         = 1'b0;
            o_branch_d       = 1'b0;
        end
    end

    // Start and done are registered so each is a clean single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_md_op    <= 3'b000;
            o_md_start <= 1'b0;
            o_md_done  <= 1'b0;
        end else begin
            o_md_start <= 1'b0;
            o_md_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md_accept) begin
                        state      <= ST_BUSY;
                        o_md_op    <= i_ctrl_funct3;
                        cnt        <= i_ctrl_funct3[2] ? DIV_LAT_M1 : MUL_LAT_M1;
                        o_md_start <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (i_ctrl_flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        state     <= ST_DONE;
                        o_md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset gates the stall so it drops in the same cycle reset is applied.
    assign o_md_stall = ~i_rst & ~i_ctrl_flush &
                        (((state == ST_IDLE) & i_ctrl_valid & md_req) | (state == ST_BUSY));

endmodule
